gat_load_bridge: RTL and testbench
==================================

# gat_load_bridge

Parametrised host-to-core load bridge for the GAT accelerator. It sits between the AXI-BRAM-controller side of the block design and `gat_top`. It replaces fixed per-BRAM port slicing with a single shared write port that carries a channel select. Per channel it converts byte addresses to word addresses, checks alignment and range, counts words against programmed lengths, and raises per-channel load-done flags. It also sequences the start/ready handshake with the core, so several layers can be reloaded without a reset.

## Interface
Parameters:
- TOP_WIDTH, 32, host data width
- DATA_W, 20, data bits forwarded to the core (low bits of host word)
- NUM_CH, 3, number of load channels (0 = h_data, 1 = h_node_info, 2 = weight by convention)
- ADDR_W, 18, word-address width per channel
- SEL_W, $clog2(NUM_CH) (min 1), channel-select width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- arm  in  1  pulse: start a load phase
- cfg_we  in  1  length-register write strobe
- cfg_sel  in  SEL_W  channel for cfg_we
- cfg_len  in  ADDR_W+1  expected word count for the channel
- s_wr  in  1  host write strobe
- s_sel  in  SEL_W  target channel
- s_addr  in  ADDR_W+2  byte address
- s_din  in  TOP_WIDTH  host data
- m_we  out  NUM_CH  one-hot core BRAM write enable
- m_addr  out  ADDR_W  core word address
- m_din  out  DATA_W  core write data (s_din[DATA_W-1:0])
- load_done  out  NUM_CH  per-channel loaded flag
- gat_layer_in  in  1  layer select from register bank
- gat_layer  out  1  layer value latched at start
- gat_start  out  1  one-cycle start pulse to core
- core_ready  in  1  core finished (level)
- gat_ready  out  1  bridge result-ready flag
- err  out  3  sticky {overflow, range, misalign}
- status  out  TOP_WIDTH  {state[2:0], zero pad, write count of channel 0 [ADDR_W:0]}

## Operation
- State machine: IDLE, LOAD, START, RUN, DONE. Reset state is IDLE.
- IDLE / DONE:
  - cfg_we writes len[cfg_sel]. cfg_we with cfg_sel ≥ NUM_CH is ignored.
  - arm moves to LOAD. On that move, all counters, load_done and err are cleared.
  - s_wr is ignored.
- LOAD:
  - A write is accepted when s_addr[1:0]==0, s_sel<NUM_CH, word address s_addr[ADDR_W+1:2] < len[s_sel], and load_done[s_sel]==0.
  - Acceptance forwards the write to the core and increments cnt[s_sel].
  - Rejections set the sticky error bits:
    - misalign: s_addr[1:0]≠0
    - range: address ≥ len, or s_sel ≥ NUM_CH
    - overflow: channel already done
  - Misalign has priority over range, and range over overflow. Only one bit is set per write.
  - load_done[c] = (cnt[c]==len[c]). A channel with len 0 is done on entry to LOAD.
  - When all load_done bits are 1, the FSM moves to START.
  - Counting is by writes, not distinct addresses. A rewritten address still counts.
- START: gat_start=1 for exactly one cycle. gat_layer latches gat_layer_in. The FSM then moves to RUN.
- RUN: waits for core_ready==1, then moves to DONE.
- DONE: gat_ready=1. arm re-enters LOAD for the next layer; gat_ready drops on that transition.
- arm is ignored in LOAD, START and RUN.
- cfg_we is ignored outside IDLE and DONE.

## Timing
- Reset values:
  - m_we, m_addr, m_din: 0
  - load_done, err, gat_start, gat_ready, gat_layer, status: 0
  - all len and cnt registers: 0
- Write latency: an accepted write at edge N drives m_we/m_addr/m_din during cycle N+1, for 1 cycle. Outputs are registered.
- load_done rises in the same cycle as the final m_we.
- LOAD→START occurs on the edge after load_done becomes all-ones. gat_start is high in the next cycle.
- Minimum from last accepted write to gat_start: 2 cycles.
- RUN→DONE happens on the edge where core_ready is sampled high. gat_ready is high the next cycle.
- If core_ready is already high when RUN is entered, the FSM moves to DONE after a single RUN cycle.
- s_wr on the same edge that IDLE→LOAD occurs is dropped.
- A write that completes the last channel and a new s_wr on the following cycle: the new write is dropped, because the FSM has left LOAD. No error bit is set.
- Asserting rst in any state returns to IDLE asynchronously. All outputs return to reset values, and the programmed lengths are lost.

## Test plan
- Basic load: program len = {4, 2, 3} in IDLE, pulse arm, issue 9 aligned writes. Expected: 9 m_we pulses, each one cycle after its write, with m_addr = byte address >> 2. load_done = 3'b111. gat_start pulses 2 cycles after the last write.
- Errors: during LOAD, write s_addr = 0x6 → err = 3'b001, no m_we. Write channel 1 at address 0x8 with len 2 → err = 3'b011. Write a done channel → err = 3'b111. cnt is unchanged throughout.
- Zero-length channel: program len = {5, 0, 1}, pulse arm → load_done[1] = 1 immediately. After 6 valid writes → START.
- Handshake: hold core_ready = 0 for 10 cycles in RUN → gat_ready stays 0. Raise core_ready → gat_ready = 1 the next cycle. gat_layer equals gat_layer_in sampled in START.
- Two-layer reload: from DONE, change len[2] to 7, set gat_layer_in = 1, pulse arm → counters, load_done and err clear and gat_ready drops. A second full load produces a second gat_start with gat_layer = 1.
- Reset mid-load: assert rst after 3 of 9 writes → all outputs are 0 and state is IDLE. Arm without reprogramming → all channels done immediately (len 0), so gat_start pulses.

Source files
------------

// File: rtl/gat_load_bridge.sv
// gat_load_bridge: shared host write port into the GAT core BRAMs.
// Converts byte addresses to word addresses per channel, validates each write
// against alignment and the programmed channel length, tracks per-channel
// completion and sequences the start/ready handshake with the core.
module gat_load_bridge #(
  parameter int TOP_WIDTH = 32,
  parameter int DATA_W    = 20,
  parameter int NUM_CH    = 3,
  parameter int ADDR_W    = 18,
  parameter int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 cfg_we,
  input  logic [SEL_W-1:0]     cfg_sel,
  input  logic [ADDR_W:0]      cfg_len,
  input  logic                 s_wr,
  input  logic [SEL_W-1:0]     s_sel,
  input  logic [ADDR_W+1:0]    s_addr,
  input  logic [TOP_WIDTH-1:0] s_din,
  output logic [NUM_CH-1:0]    m_we,
  output logic [ADDR_W-1:0]    m_addr,
  output logic [DATA_W-1:0]    m_din,
  output logic [NUM_CH-1:0]    load_done,
  input  logic                 gat_layer_in,
  output logic                 gat_layer,
  output logic                 gat_start,
  input  logic                 core_ready,
  output logic                 gat_ready,
  output logic [2:0]           err,
  output logic [TOP_WIDTH-1:0] status
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  state_e              state_q;
  logic [ADDR_W:0]     len_q [NUM_CH];
  logic [ADDR_W:0]     len_d [NUM_CH];
  logic [ADDR_W:0]     cnt_q [NUM_CH];
  logic [NUM_CH-1:0]   done_q;
  logic [NUM_CH-1:0]   we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic [2:0]          err_q;
  logic                start_q;
  logic                ready_q;
  logic                layer_q;

  logic [ADDR_W-1:0]   waddr;
  logic [NUM_CH-1:0]   sel_oh;
  logic [ADDR_W:0]     sel_len;
  logic                sel_done;
  logic                wr_live;
  logic                misalign;
  logic                range_err;
  logic                overflow;
  logic                accept;

  assign waddr = s_addr[ADDR_W+1:2];

  if (TOP_WIDTH > DATA_W) begin : g_unused
    logic unused_din_hi;
    assign unused_din_hi = ^s_din[TOP_WIDTH-1:DATA_W];
  end

  // Length registers as they would be after this cycle's config write.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      len_d[c] = (cfg_we && (cfg_sel == c[SEL_W-1:0])) ? cfg_len : len_q[c];
    end
  end

  // Classify the host write against the selected channel.
  // Once every channel is done the FSM is committed to START, so a write in
  // that last LOAD cycle is dropped silently rather than flagged as overflow.
  always_comb begin
    sel_oh   = '0;
    sel_len  = '0;
    sel_done = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (s_sel == c[SEL_W-1:0]) begin
        sel_oh[c] = 1'b1;
        sel_len   = len_q[c];
        sel_done  = done_q[c];
      end
    end
    wr_live   = s_wr && (state_q == S_LOAD) && !(&done_q);
    misalign  = (s_addr[1:0] != 2'b00);
    range_err = !(|sel_oh) || ({1'b0, waddr} >= sel_len);
    overflow  = sel_done;
    accept    = wr_live && !misalign && !range_err && !overflow;
  end

  // Control FSM with registered core-side outputs, counters and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        len_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      done_q  <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      layer_q <= 1'b0;
    end else begin
      we_q    <= '0;
      start_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            len_q[c] <= len_d[c];
          end
          if (arm) begin
            state_q <= S_LOAD;
            err_q   <= '0;
            ready_q <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              cnt_q[c]  <= '0;
              done_q[c] <= (len_d[c] == '0);
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            we_q   <= sel_oh;
            addr_q <= waddr;
            din_q  <= s_din[DATA_W-1:0];
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              if (sel_oh[c]) begin
                cnt_q[c] <= cnt_q[c] + CNT_ONE;
                if ((cnt_q[c] + CNT_ONE) == len_q[c]) begin
                  done_q[c] <= 1'b1;
                end
              end
            end
          end else if (wr_live) begin
            if (misalign) begin
              err_q[0] <= 1'b1;
            end else if (range_err) begin
              err_q[1] <= 1'b1;
            end else begin
              err_q[2] <= 1'b1;
            end
          end
          if (&done_q) begin
            state_q <= S_START;
            start_q <= 1'b1;
          end
        end
        S_START: begin
          state_q <= S_RUN;
          layer_q <= gat_layer_in;
        end
        S_RUN: begin
          if (core_ready) begin
            state_q <= S_DONE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Debug status word: state in the top bits, channel 0 write count at the bottom.
  always_comb begin
    status = '0;
    status[TOP_WIDTH-1 -: 3] = state_q;
    status[ADDR_W:0]         = cnt_q[0];
  end

  assign m_we      = we_q;
  assign m_addr    = addr_q;
  assign m_din     = din_q;
  assign load_done = done_q;
  assign err       = err_q;
  assign gat_start = start_q;
  assign gat_ready = ready_q;
  assign gat_layer = layer_q;

endmodule

// File: tb/tb_gat_load_bridge.sv
// Randomized self-checking bench for gat_load_bridge with a transaction-level
// reference model of channel lengths, write counts, done flags and errors.
module tb_gat_load_bridge;

  localparam int TW = 32;
  localparam int DW = 20;
  localparam int NC = 3;
  localparam int AW = 18;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          cfg_we;
  logic [SW-1:0] cfg_sel;
  logic [AW:0]   cfg_len;
  logic          s_wr;
  logic [SW-1:0] s_sel;
  logic [AW+1:0] s_addr;
  logic [TW-1:0] s_din;
  logic [NC-1:0] m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [NC-1:0] load_done;
  logic          gat_layer_in;
  logic          gat_layer;
  logic          gat_start;
  logic          core_ready;
  logic          gat_ready;
  logic [2:0]    err;
  logic [TW-1:0] status;

  gat_load_bridge #(
    .TOP_WIDTH(TW),
    .DATA_W   (DW),
    .NUM_CH   (NC),
    .ADDR_W   (AW),
    .SEL_W    (SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_len     (cfg_len),
    .s_wr        (s_wr),
    .s_sel       (s_sel),
    .s_addr      (s_addr),
    .s_din       (s_din),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_din       (m_din),
    .load_done   (load_done),
    .gat_layer_in(gat_layer_in),
    .gat_layer   (gat_layer),
    .gat_start   (gat_start),
    .core_ready  (core_ready),
    .gat_ready   (gat_ready),
    .err         (err),
    .status      (status)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned pulses = 0;

  // Reference model state
  int          len_m [NC];
  int          cnt_m [NC];
  logic [NC-1:0] done_m;
  logic [2:0]  err_m;
  logic        layer_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    s_wr   = 1'b0;
    arm    = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      len_m[c] = 0;
      cnt_m[c] = 0;
    end
    done_m  = '0;
    err_m   = '0;
    layer_m = 1'b0;
  endtask

  task automatic check_load_outputs(input logic [NC-1:0] we_e, input logic [AW-1:0] a_e,
                                    input logic [DW-1:0] d_e);
    if (m_we != 0) pulses++;
    chk("m_we", m_we, we_e);
    if (we_e != 0) begin
      chk("m_addr", m_addr, a_e);
      chk("m_din", m_din, d_e);
    end
    chk("err", err, err_m);
    chk("load_done", load_done, done_m);
    chk("cnt0", status[AW:0], cnt_m[0]);
    chk("gat_start_low", gat_start, 0);
  endtask

  task automatic noise_cfg(input bit en);
    cfg_we  = en && ($urandom_range(0, 3) == 0);
    cfg_sel = SW'($urandom_range(0, 3));
    cfg_len = (AW+1)'($urandom_range(0, 9));
    arm     = en && ($urandom_range(0, 3) == 0);
  endtask

  // One host write in LOAD; the model applies the acceptance rules.
  task automatic do_write(input int sel, input int addr, input logic [31:0] din, input bit noise);
    logic [NC-1:0] we_e;
    int wa;
    we_e = '0;
    wa   = addr / 4;
    s_wr   = 1'b1;
    s_sel  = sel[SW-1:0];
    s_addr = addr[AW+1:0];
    s_din  = din;
    noise_cfg(noise);
    if (!(&done_m)) begin
      if (addr % 4 != 0) err_m[0] = 1'b1;
      else if (sel >= NC) err_m[1] = 1'b1;
      else if (wa >= len_m[sel]) err_m[1] = 1'b1;
      else if (done_m[sel]) err_m[2] = 1'b1;
      else begin
        cnt_m[sel]++;
        if (cnt_m[sel] == len_m[sel]) done_m[sel] = 1'b1;
        we_e[sel] = 1'b1;
      end
    end
    step();
    drive_idle();
    check_load_outputs(we_e, wa[AW-1:0], din[DW-1:0]);
  endtask

  task automatic idle_cycle(input bit noise);
    s_wr = 1'b0;
    noise_cfg(noise);
    step();
    drive_idle();
    check_load_outputs('0, '0, '0);
  endtask

  task automatic prog(input int l0, input int l1, input int l2);
    int l [NC];
    l[0] = l0; l[1] = l1; l[2] = l2;
    for (int c = 0; c < NC; c++) begin
      cfg_we = 1'b1; cfg_sel = SW'(c); cfg_len = (AW+1)'(l[c]);
      step();
      len_m[c] = l[c];
    end
    cfg_we = 1'b1; cfg_sel = SW'(3); cfg_len = (AW+1)'($urandom_range(1, 9));
    step();
    drive_idle();
  endtask

  // Arm a load phase; a write on the same edge must be dropped.
  task automatic arm_load(input logic layer);
    gat_layer_in = layer;
    layer_m      = layer;
    arm  = 1'b1;
    s_wr = 1'b1; s_sel = '0; s_addr = '0; s_din = $urandom;
    step();
    drive_idle();
    for (int c = 0; c < NC; c++) begin
      cnt_m[c]  = 0;
      done_m[c] = (len_m[c] == 0);
    end
    err_m = '0;
    chk("arm_m_we", m_we, 0);
    chk("arm_load_done", load_done, done_m);
    chk("arm_err", err, 0);
    chk("arm_ready_drop", gat_ready, 0);
    chk("arm_cnt0", status[AW:0], 0);
  endtask

  task automatic run_load(input bit mixed);
    int guard, r, sel, addr, off, c;
    guard = 0;
    while (!(&done_m) && guard < 400) begin
      guard++;
      r    = mixed ? int'($urandom_range(0, 9)) : 0;
      sel  = 0;
      addr = 0;
      if (r < 5) begin
        off = $urandom_range(0, NC - 1);
        for (int k = 0; k < NC; k++) begin
          c = (off + k) % NC;
          if (!done_m[c]) sel = c;
        end
        addr = 4 * int'($urandom_range(0, len_m[sel] - 1));
      end else if (r == 5) begin
        sel  = $urandom_range(0, 3);
        addr = 4 * int'($urandom_range(0, 7)) + int'($urandom_range(1, 3));
      end else if (r == 6) begin
        sel  = 3;
        addr = 4 * int'($urandom_range(0, 3));
      end else if (r == 7) begin
        sel  = $urandom_range(0, NC - 1);
        addr = 4 * (len_m[sel] + int'($urandom_range(0, 3)));
      end else if (r == 8) begin
        sel  = $urandom_range(0, NC - 1);
        addr = (len_m[sel] > 0) ? 4 * int'($urandom_range(0, len_m[sel] - 1)) : 0;
      end
      if (r == 9) idle_cycle(mixed);
      else do_write(sel, addr, $urandom, mixed);
    end
    chk("all_done", load_done, {NC{1'b1}});
  endtask

  // Cycle after completion: trailing write is dropped, gat_start pulses once.
  task automatic finish_load();
    s_wr = 1'b1; s_sel = '0; s_addr = '0; s_din = $urandom; arm = 1'b1;
    step();
    drive_idle();
    chk("drop_m_we", m_we, 0);
    chk("drop_err", err, err_m);
    chk("drop_cnt0", status[AW:0], cnt_m[0]);
    chk("gat_start", gat_start, 1);
    chk("ready_in_start", gat_ready, 0);
    step();
    chk("gat_start_one", gat_start, 0);
    chk("gat_layer", gat_layer, layer_m);
  endtask

  task automatic run_core(input int wait_cycles);
    core_ready = 1'b0;
    for (int i = 0; i < wait_cycles; i++) begin
      arm = ($urandom_range(0, 2) == 0);
      step();
      arm = 1'b0;
      chk("ready_wait", gat_ready, 0);
      chk("start_in_run", gat_start, 0);
    end
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    chk("gat_ready", gat_ready, 1);
    chk("layer_hold", gat_layer, layer_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arm = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_len = '0;
    s_wr = 1'b0; s_sel = '0; s_addr = '0; s_din = '0;
    gat_layer_in = 1'b0; core_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_din", m_din, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_err", err, 0);
    chk("rst_gat_start", gat_start, 0);
    chk("rst_gat_ready", gat_ready, 0);
    chk("rst_gat_layer", gat_layer, 0);
    chk("rst_status", status, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Basic load of nine valid writes
    prog(4, 2, 3);
    arm_load(1'b0);
    pulses = 0;
    run_load(1'b0);
    chk("m_we_pulses", pulses, 9);
    finish_load();
    run_core(10);

    // Directed errors with a zero-length channel, then random traffic
    prog(5, 0, 1);
    arm_load(1'b1);
    do_write(0, 6, $urandom, 1'b0);
    chk("err_misalign", err, 3'b001);
    do_write(1, 8, $urandom, 1'b0);
    chk("err_range", err, 3'b011);
    do_write(2, 0, $urandom, 1'b0);
    do_write(2, 0, $urandom, 1'b0);
    chk("err_overflow", err, 3'b111);
    run_load(1'b1);
    finish_load();
    run_core(0);

    // Reload from DONE with new length and layer
    cfg_we = 1'b1; cfg_sel = SW'(2); cfg_len = (AW+1)'(7);
    step();
    drive_idle();
    len_m[2] = 7;
    arm_load(1'b1);
    run_load(1'b1);
    finish_load();
    run_core($urandom_range(1, 4));

    // Random layers
    for (int t = 0; t < 5; t++) begin
      prog($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      arm_load(1'($urandom_range(0, 1)));
      run_load(1'b1);
      finish_load();
      run_core($urandom_range(0, 5));
    end

    // Reset in the middle of a load
    prog(4, 2, 3);
    arm_load(1'b0);
    do_write(0, 0, $urandom, 1'b0);
    do_write(1, 4, $urandom, 1'b0);
    do_write(2, 8, $urandom, 1'b0);
    rst = 1'b1;
    #2;
    chk("mrst_m_we", m_we, 0);
    chk("mrst_m_addr", m_addr, 0);
    chk("mrst_m_din", m_din, 0);
    chk("mrst_load_done", load_done, 0);
    chk("mrst_err", err, 0);
    chk("mrst_status", status, 0);
    chk("mrst_gat_ready", gat_ready, 0);
    rst = 1'b0;
    model_reset();
    arm_load(1'b1);
    finish_load();
    run_core(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
